// File: rtl/dmem_pkg.sv
`default_nettype none
//==============================================================================
// Module   : dmem_pkg
// Brief    : Size/state encodings and byte-count helper shared by dmem_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] CHECK = 2'd1;
    localparam logic [STATE_W-1:0] XFER  = 2'd2;
    localparam logic [STATE_W-1:0] DONE  = 2'd3;

    // Illegal size maps to zero bytes; the controller rejects it before use.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ctrl_byte_ram.sv
`default_nettype none
//==============================================================================
// Module   : byte_ram
// Brief    : Single-port 8-bit RAM, synchronous read.
// Revision : 1.0 - initial release
//==============================================================================
module byte_ram
    import dmem_pkg::*;
#(
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [0:(2**ADDR_W)-1];
    logic [7:0] r_rdata;

    // Read-before-write: a store cycle returns the old byte, which is discarded.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : dmem_ctrl
// Brief    : Byte-serial little-endian data memory controller for the LSU.
//            Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word.
// Revision : 1.0 - initial release
//==============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int    ADDR_W    = 10,
    parameter int    XLEN      = 32,
    parameter string INIT_FILE = ""
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [1:0]        REQ_SIZE,
    input  logic              REQ_UNSIGNED,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [XLEN-1:0]   REQ_WDATA,
    output logic              RSP_VALID,
    output logic [XLEN-1:0]   RSP_RDATA,
    output logic              RSP_ERR
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;

    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [2:0]        r_cnt;
    logic [XLEN-1:0]   r_buf;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_rsp_err;

    logic [2:0]        w_n;
    logic [ADDR_W:0]   w_end_excl;
    logic              w_oob;
    logic              w_misalign;
    logic              w_err;
    logic              w_last;
    logic [1:0]        w_lane;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [7:0]        w_ram_wdata;
    logic [7:0]        w_ram_rdata;
    logic [XLEN-1:0]   w_asm;
    logic [XLEN-1:0]   w_ext;

    assign w_n        = size_bytes(r_size);
    // One past the last byte; anything beyond the memory top is rejected.
    assign w_end_excl = {1'b0, r_addr} + {{(ADDR_W-2){1'b0}}, w_n};
    assign w_oob      = w_end_excl > {1'b1, {ADDR_W{1'b0}}};

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = ((r_size == SZ_HALF) && r_addr[0]) ||
                        ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err  = (r_size == SZ_ILL) || w_oob || w_misalign;
    assign w_last = (r_cnt == w_n);

    // Byte k is addressed while r_cnt==k and its read data lands at r_cnt==k+1.
    assign w_lane      = r_cnt[1:0] - 2'd1;
    assign w_ram_addr  = r_addr + {{(ADDR_W-3){1'b0}}, r_cnt};
    assign w_ram_wdata = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
    assign w_ram_we    = (r_state == XFER) && r_we && (r_cnt < w_n) && !RST;

    byte_ram #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (CLK),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_asm = r_buf;
        w_asm[{w_lane, 3'b000} +: 8] = w_ram_rdata;
    end

    always_comb begin
        w_ext = w_asm;
        case (r_size)
            SZ_BYTE: w_ext = r_uns ? {{(XLEN-8){1'b0}}, w_asm[7:0]}
                                   : {{(XLEN-8){w_asm[7]}}, w_asm[7:0]};
            SZ_HALF: w_ext = r_uns ? {{(XLEN-16){1'b0}}, w_asm[15:0]}
                                   : {{(XLEN-16){w_asm[15]}}, w_asm[15:0]};
            default: w_ext = w_asm;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (REQ_VALID) w_state_nxt = CHECK;
            CHECK:   w_state_nxt = w_err ? DONE : XFER;
            XFER:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_size      <= SZ_BYTE;
            r_uns       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (REQ_VALID) begin
                        r_we    <= REQ_WE;
                        r_size  <= REQ_SIZE;
                        r_uns   <= REQ_UNSIGNED;
                        r_addr  <= REQ_ADDR;
                        r_wdata <= REQ_WDATA;
                        r_buf   <= '0;
                        r_cnt   <= '0;
                    end
                end
                CHECK: begin
                    if (w_err) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end
                end
                XFER: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt != 3'd0) begin
                        r_buf <= w_asm;
                    end
                    if (w_last) begin
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_we ? '0 : w_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign REQ_READY = (r_state == IDLE);
    assign RSP_VALID = (r_state == DONE);
    assign RSP_RDATA = r_rsp_rdata;
    assign RSP_ERR   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_dmem_ctrl
// Brief    : Self-checking bench for dmem_ctrl against a byte-array memory model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_dmem_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WE = 1'b0;
    logic [1:0]    REQ_SIZE = 2'b00;
    logic          REQ_UNSIGNED = 1'b0;
    logic [AW-1:0] REQ_ADDR = '0;
    logic [31:0]   REQ_WDATA = '0;
    logic          RSP_VALID;
    logic [31:0]   RSP_RDATA;
    logic          RSP_ERR;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_m [0:DEPTH-1];

    dmem_ctrl #(
        .ADDR_W    (AW),
        .XLEN      (32),
        .INIT_FILE ("")
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .REQ_VALID    (REQ_VALID),
        .REQ_READY    (REQ_READY),
        .REQ_WE       (REQ_WE),
        .REQ_SIZE     (REQ_SIZE),
        .REQ_UNSIGNED (REQ_UNSIGNED),
        .REQ_ADDR     (REQ_ADDR),
        .REQ_WDATA    (REQ_WDATA),
        .RSP_VALID    (RSP_VALID),
        .RSP_RDATA    (RSP_RDATA),
        .RSP_ERR      (RSP_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic int nbytes(input bit [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    endfunction

    function automatic bit model_err(input bit [1:0] sz, input int addr);
        bit e;
        e = (sz == 2'd3) || (addr + nbytes(sz) > DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (sz == 2'd1 && (addr % 2) != 0) e = 1'b1;
        if (sz == 2'd2 && (addr % 4) != 0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] model_load(input bit [1:0] sz, input bit uns, input int addr);
        longint v;
        int     n;
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(mem_m[addr+i]) << (8*i));
        // Signed value = raw - 2^(8n) when the top bit is set.
        if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    task automatic model_store(input bit [1:0] sz, input int addr, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) mem_m[addr+i] = wd[8*i +: 8];
    endtask

    // Issue one request from posedge+1 and wait for its response; lat=-1 on timeout.
    task automatic do_req(input bit we, input bit [1:0] sz, input bit uns, input int addr,
                          input logic [31:0] wd, output logic [31:0] rd, output bit er,
                          output int lat);
        int g;
        g = 0;
        while (!REQ_READY && g < 50) begin
            @(posedge CLK); #1; g++;
        end
        REQ_WE = we; REQ_SIZE = sz; REQ_UNSIGNED = uns;
        REQ_ADDR = addr[AW-1:0]; REQ_WDATA = wd; REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        REQ_ADDR = AW'($urandom); REQ_WDATA = $urandom; REQ_SIZE = 2'($urandom);
        rd = 'x; er = 1'bx; lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (RSP_VALID) begin
                lat = k + 1; rd = RSP_RDATA; er = RSP_ERR;
                break;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", REQ_READY); end
        checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", RSP_VALID); end
        checks++; if (RSP_RDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=0", RSP_RDATA); end
        checks++; if (RSP_ERR !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", RSP_ERR); end
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_fill();
        logic [31:0] rd, wd;
        bit er;
        int lat, bad;
        bad = 0;
        for (int a = 0; a < DEPTH; a += 4) begin
            wd = $urandom;
            do_req(1'b1, 2'd2, 1'b0, a, wd, rd, er, lat);
            if (er !== 1'b0 || lat != 7 || rd !== 32'h0) bad++;
            model_store(2'd2, a, wd);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL fill_stores bad=%0d want=0", bad); end
    endtask

    typedef struct {
        bit          we;
        bit [1:0]    sz;
        bit          uns;
        int          addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          lat;
    } op_t;

    task automatic test_basic();
        op_t ops[11] = '{
            '{1'b1, 2'd0, 1'b0, 0, 32'h000000FF, 32'h0, 4},
            '{1'b1, 2'd0, 1'b0, 1, 32'h00000000, 32'h0, 4},
            '{1'b1, 2'd0, 1'b0, 2, 32'h000000FF, 32'h0, 4},
            '{1'b1, 2'd0, 1'b0, 3, 32'h00000000, 32'h0, 4},
            '{1'b0, 2'd2, 1'b0, 0, 32'h0, 32'h00FF00FF, 7},
            '{1'b0, 2'd0, 1'b0, 0, 32'h0, 32'hFFFFFFFF, 4},
            '{1'b0, 2'd0, 1'b1, 0, 32'h0, 32'h000000FF, 4},
            '{1'b0, 2'd1, 1'b0, 2, 32'h0, 32'h000000FF, 5},
            '{1'b1, 2'd1, 1'b0, 4, 32'h00008001, 32'h0, 5},
            '{1'b0, 2'd1, 1'b0, 4, 32'h0, 32'hFFFF8001, 5},
            '{1'b0, 2'd1, 1'b1, 4, 32'h0, 32'h00008001, 5}
        };
        logic [31:0] rd;
        bit er;
        int lat;
        for (int i = 0; i < 11; i++) begin
            do_req(ops[i].we, ops[i].sz, ops[i].uns, ops[i].addr, ops[i].wd, rd, er, lat);
            checks++;
            if (rd !== ops[i].rd || er !== 1'b0 || lat != ops[i].lat) begin
                errors++;
                $display("FAIL basic[%0d] got rd=%h err=%b lat=%0d want rd=%h err=0 lat=%0d",
                         i, rd, er, lat, ops[i].rd, ops[i].lat);
            end
            if (ops[i].we) model_store(ops[i].sz, ops[i].addr, ops[i].wd);
        end
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (RSP_RDATA !== 32'h00008001) begin
            errors++; $display("FAIL rdata_hold got=%h want=00008001", RSP_RDATA);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, exp_rd;
        bit er;
        int lat;
`ifdef DMEM_MISALIGN_TRAP_EN
        do_req(1'b1, 2'd2, 1'b0, 5, 32'hDEADBEEF, rd, er, lat);
        checks++; if (er !== 1'b1 || lat != 2) begin errors++; $display("FAIL mis_sw got err=%b lat=%0d want err=1 lat=2", er, lat); end
        do_req(1'b0, 2'd2, 1'b0, 5, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || lat != 2 || rd !== 32'h0) begin errors++; $display("FAIL mis_lw got rd=%h err=%b lat=%0d want rd=0 err=1 lat=2", rd, er, lat); end
        exp_rd = model_load(2'd0, 1'b0, 5);
        do_req(1'b0, 2'd0, 1'b0, 5, 32'h0, rd, er, lat);
        checks++; if (rd !== exp_rd || er !== 1'b0 || lat != 4) begin errors++; $display("FAIL mis_lb got rd=%h err=%b lat=%0d want rd=%h err=0 lat=4", rd, er, lat, exp_rd); end
`else
        do_req(1'b1, 2'd2, 1'b0, 5, 32'hDEADBEEF, rd, er, lat);
        checks++; if (er !== 1'b0 || lat != 7) begin errors++; $display("FAIL mis_sw got err=%b lat=%0d want err=0 lat=7", er, lat); end
        model_store(2'd2, 5, 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 5, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 7) begin errors++; $display("FAIL mis_lw got rd=%h err=%b lat=%0d want rd=deadbeef err=0 lat=7", rd, er, lat); end
        exp_rd = model_load(2'd0, 1'b0, 6);
        do_req(1'b0, 2'd0, 1'b0, 6, 32'h0, rd, er, lat);
        checks++; if (rd !== exp_rd || lat != 4) begin errors++; $display("FAIL mis_lb got rd=%h lat=%0d want rd=%h lat=4", rd, lat, exp_rd); end
`endif
    endtask

    task automatic test_errors();
        logic [31:0] rd, exp_rd;
        bit er;
        int lat;
        do_req(1'b0, 2'd2, 1'b0, 'h3FE, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 2) begin errors++; $display("FAIL err_oob_lw got rd=%h err=%b lat=%0d want rd=0 err=1 lat=2", rd, er, lat); end
        do_req(1'b1, 2'd3, 1'b0, 0, 32'hA5A5A5A5, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 2) begin errors++; $display("FAIL err_size got rd=%h err=%b lat=%0d want rd=0 err=1 lat=2", rd, er, lat); end
        do_req(1'b1, 2'd2, 1'b0, 'h3FE, 32'h5A5A5A5A, rd, er, lat);
        checks++; if (er !== 1'b1 || lat != 2) begin errors++; $display("FAIL err_oob_sw got err=%b lat=%0d want err=1 lat=2", er, lat); end
        exp_rd = model_load(2'd2, 1'b0, 'h3FC);
        do_req(1'b0, 2'd2, 1'b0, 'h3FC, 32'h0, rd, er, lat);
        checks++; if (rd !== exp_rd || er !== 1'b0) begin errors++; $display("FAIL err_top_intact got=%h want=%h", rd, exp_rd); end
        exp_rd = model_load(2'd2, 1'b0, 0);
        do_req(1'b0, 2'd2, 1'b0, 0, 32'h0, rd, er, lat);
        checks++; if (rd !== exp_rd || er !== 1'b0) begin errors++; $display("FAIL err_low_intact got=%h want=%h", rd, exp_rd); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, exp_rd;
        bit er, seen;
        int lat;
        while (!REQ_READY) begin @(posedge CLK); #1; end
        REQ_WE = 1'b1; REQ_SIZE = 2'd2; REQ_UNSIGNED = 1'b0;
        REQ_ADDR = 'h010; REQ_WDATA = 32'h11223344; REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        checks++; if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1 || RSP_RDATA !== 32'h0 || RSP_ERR !== 1'b0) begin
            errors++; $display("FAIL abort_outputs got valid=%b ready=%b rdata=%h err=%b want 0 1 0 0", RSP_VALID, REQ_READY, RSP_RDATA, RSP_ERR);
        end
        seen = 1'b0;
        repeat (10) begin @(posedge CLK); #1; if (RSP_VALID) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_rsp got pulse=%b want=0", seen); end
        mem_m['h010] = 8'h44;
        mem_m['h011] = 8'h33;
        exp_rd = model_load(2'd2, 1'b0, 'h010);
        do_req(1'b0, 2'd2, 1'b0, 'h010, 32'h0, rd, er, lat);
        checks++; if (rd !== exp_rd || er !== 1'b0 || lat != 7) begin errors++; $display("FAIL abort_partial got rd=%h lat=%0d want rd=%h lat=7", rd, lat, exp_rd); end
    endtask

    task automatic test_hold_valid();
        logic [32:0] q[$];
        logic [32:0] e;
        bit [1:0] sz;
        bit we, uns, inflight, eer;
        int addr, acc, pulses, cyc;
        logic [31:0] wd;
        inflight = 1'b0; acc = 0; pulses = 0; cyc = 0;
        while (!REQ_READY) begin @(posedge CLK); #1; end
        while ((cyc < 80 || inflight) && cyc < 300) begin
            if (RSP_VALID) begin
                pulses++;
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL hold_spurious_rsp cycle=%0d", cyc);
                end else begin
                    e = q.pop_front();
                    if (RSP_RDATA !== e[31:0] || RSP_ERR !== e[32] || REQ_READY !== 1'b0) begin
                        errors++;
                        $display("FAIL hold_rsp got rd=%h err=%b ready=%b want rd=%h err=%b ready=0", RSP_RDATA, RSP_ERR, REQ_READY, e[31:0], e[32]);
                    end
                end
                inflight = 1'b0;
            end else if (inflight && REQ_READY) begin
                checks++; errors++;
                $display("FAIL hold_ready got=1 want=0 cycle=%0d", cyc);
            end
            if (REQ_READY && cyc < 80) begin
                we = 1'($urandom); uns = 1'($urandom);
                sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                addr = $urandom_range('h20, 'h3F); wd = $urandom;
                eer = model_err(sz, addr);
                q.push_back({eer, (eer || we) ? 32'h0 : model_load(sz, uns, addr)});
                if (we && !eer) model_store(sz, addr, wd);
                REQ_WE = we; REQ_SIZE = sz; REQ_UNSIGNED = uns;
                REQ_ADDR = addr[AW-1:0]; REQ_WDATA = wd;
                inflight = 1'b1; acc++;
            end else begin
                REQ_ADDR = AW'($urandom); REQ_WDATA = $urandom;
                REQ_WE = 1'($urandom); REQ_SIZE = 2'($urandom);
            end
            REQ_VALID = (cyc < 80);
            @(posedge CLK); #1;
            cyc++;
        end
        REQ_VALID = 1'b0;
        checks++;
        if (pulses != acc || q.size() != 0 || acc == 0) begin
            errors++; $display("FAIL hold_count got pulses=%0d pending=%0d want pulses=%0d pending=0", pulses, q.size(), acc);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, exp_rd;
        bit [1:0] sz;
        bit we, uns, eer;
        int addr, lat, exp_lat;
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom); uns = 1'($urandom); wd = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH-6, DEPTH-1) : $urandom_range(0, DEPTH-1);
            eer = model_err(sz, addr);
            exp_rd = (eer || we) ? 32'h0 : model_load(sz, uns, addr);
            exp_lat = eer ? 2 : nbytes(sz) + 3;
            do_req(we, sz, uns, addr, wd, rd, eer === 1'b1 ? eer : eer, lat);
            checks++;
            if (rd !== exp_rd || lat != exp_lat || RSP_ERR !== model_err(sz, addr)) begin
                errors++;
                $display("FAIL rand[%0d] we=%b sz=%0d addr=%h got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                         i, we, sz, addr, rd, RSP_ERR, lat, exp_rd, model_err(sz, addr), exp_lat);
            end
            if (we && !model_err(sz, addr)) model_store(sz, addr, wd);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_misalign();
        test_errors();
        test_reset_abort();
        test_hold_valid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
